alu_core: RTL and testbench
===========================

// Module: alu_core
// PURPOSE
//  Arithmetic unit directly downstream of the alu_in bus. Accepts op/a/b on a valid/ready
//  handshake and runs single-cycle logic ops or an iterative shift-add multiply.
//  Presents a 2*W-bit result with a one-cycle done pulse to the alu_out stage.
// PARAMETERS
//  ALU_IN_OP_WIDTH  8  operand width W of a and b; result is 2*W bits
// PORTS
//  clk      input   1      clock; all logic on posedge
//  rst      input   1      synchronous, active-high system reset
//  alu_rst  input   1      synchronous, active-high soft reset from the alu_in bus; same effect as rst
//  ready    output  1      unit can accept a command this cycle
//  valid    input   1      command present on op/a/b
//  op       input   3      opcode (alu_op_t)
//  a        input   W      operand A, unsigned
//  b        input   W      operand B, unsigned
//  done     output  1      one-cycle pulse: result updated
//  result   output  2*W    last completed result; holds between dones
// BEHAVIOUR
//  Clocking: one clock (clk); reset synchronous, active-high; rst and alu_rst OR'd, override everything.
//  Reset values: ready=0, done=0, result=0, state=IDLE, mul counter=0.
//  ready is registered: 1 from the first edge at which rst=alu_rst=0.
//  Accept = valid & ready sampled at edge E0. valid while ready=0 is ignored, never queued.
//  Opcodes: 0 NO_OP, 1 ADD, 2 AND, 3 XOR, 4 MUL, 7 RST_OP; 5,6 are treated as NO_OP.
//  FSM states: IDLE, EXEC, MUL.
//   IDLE: ready=1.
//    ADD/AND/XOR -> capture a/b/op, ready<=0, go to EXEC.
//    MUL -> capture a/b, cnt<=0, ready<=0, go to MUL.
//    NO_OP -> no state change, no done, result holds.
//    RST_OP -> result<=0, no done, stay IDLE, ready stays 1.
//   EXEC: at edge E0+1: result<=op(a,b), done<=1, ready<=1, go to IDLE.
//   MUL: one multiplier bit per edge, E0+1..E0+W.
//    At the edge where cnt==W-1 (E0+W): result<=product, done<=1, ready<=1, go to IDLE.
//  Latency: logic ops done at E0+1; MUL done at E0+W.
//   Earliest next accept is the edge after done (throughput 1 per 2 cycles for logic ops).
//  done is high exactly one cycle; it deasserts on the next edge unconditionally.
//  Widths: ADD = zero-extended W+1-bit sum (carry in bit W), upper bits 0.
//   AND/XOR = zero-extended to 2*W.
//   MUL = full unsigned 2*W product, no truncation.
//  Reset mid-operation (EXEC or MUL): abort, no done. result=0; ready low during reset,
//   high one edge after release.
//  Operand changes on a/b after accept have no effect (captured registers only).
// STRUCTURE
//  alu_pkg (shared with the alu_in/alu_out agents):
//   typedef enum logic [2:0] alu_op_t {NO_OP=0, ADD_OP=1, AND_OP=2, XOR_OP=3, MUL_OP=4, RST_OP=7}
//   typedef enum logic [1:0] alu_state_t {IDLE, EXEC, MUL}
//  Sub-module alu_shift_add_mul #(W): start/operands in, one bit per cycle,
//   last_bit flag and 2*W product out; reset via the same OR'd reset.
//  alu_core holds the FSM, handshake, logic ops, result/done registers.
// TESTING (W=8)
//  1. rst high 2 cycles, alu_rst low -> ready=0, done=0, result=16'h0000.
//     After rst falls, ready=1 at the next edge.
//  2. ADD a=8'hFF b=8'h01 -> ready low 1 cycle; done at E0+1 for 1 cycle; result=16'h0100.
//  3. MUL a=8'hFF b=8'hFF -> ready low 8 cycles; done at E0+8; result=16'hFE01.
//     valid pulses during busy are ignored.
//  4. AND a=8'hF0 b=8'h3C -> result=16'h0030.
//     XOR a=8'hF0 b=8'h3C at the first ready edge -> result=16'h00CC; two done pulses.
//  5. MUL a=8'h12 b=8'h34, alu_rst high at E0+3 for 1 cycle -> no done, result=16'h0000.
//     ready=1 one edge after release; a new ADD 8'h02+8'h03 then gives 16'h0005.
//  6. With result=16'h0100: NO_OP -> no done, result holds; op=5 -> same as NO_OP.
//     RST_OP -> result=16'h0000, no done, ready stays 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the alu_in / alu_core / alu_out path.
package alu_pkg;

  localparam int unsigned ALU_DEF_W = 8;

  typedef enum logic [2:0] {
    NO_OP  = 3'd0,
    ADD_OP = 3'd1,
    AND_OP = 3'd2,
    XOR_OP = 3'd3,
    MUL_OP = 3'd4,
    RST_OP = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per clock after start.
// product_c is the full product during the cycle in which last_bit_c is high.
module alu_shift_add_mul #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           last_bit_c,
  output logic [2*W-1:0] product_c
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  logic [PW-1:0] mcand_q, mcand_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [W-1:0]  mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] partial_c;

  // Product includes the bit being consumed this cycle, so it is final on the last bit.
  always_comb begin
    partial_c  = mplier_q[0] ? mcand_q : '0;
    product_c  = acc_q + partial_c;
    last_bit_c = busy_q && (cnt_q == CW'(W - 1));

    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;

    if (start) begin
      mcand_d  = PW'(a);
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = product_c;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last_bit_c) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_core.sv
// ALU between the alu_in and alu_out stages: single-cycle logic ops and an
// iterative multiply behind a valid/ready handshake, with a done pulse per result.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned ALU_IN_OP_WIDTH = ALU_DEF_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_rst,
  output logic                         ready,
  input  logic                         valid,
  input  logic [2:0]                   op,
  input  logic [ALU_IN_OP_WIDTH-1:0]   a,
  input  logic [ALU_IN_OP_WIDTH-1:0]   b,
  output logic                         done,
  output logic [2*ALU_IN_OP_WIDTH-1:0] result
);

  localparam int unsigned W  = ALU_IN_OP_WIDTH;
  localparam int unsigned RW = 2 * W;

  alu_state_t    state_q, state_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic [RW-1:0] result_q, result_d;
  alu_op_t       op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;

  logic          rst_all_c;
  logic          mul_start_c;
  logic          mul_last_c;
  logic [RW-1:0] mul_product_c;

  assign rst_all_c = rst | alu_rst;

  alu_shift_add_mul #(.W(W)) u_mul (
    .clk        (clk),
    .rst        (rst_all_c),
    .start      (mul_start_c),
    .a          (a),
    .b          (b),
    .last_bit_c (mul_last_c),
    .product_c  (mul_product_c)
  );

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    result_d    = result_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    mul_start_c = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (valid && ready_q) begin
          case (alu_op_t'(op))
            ADD_OP, AND_OP, XOR_OP: begin
              op_d    = alu_op_t'(op);
              a_d     = a;
              b_d     = b;
              ready_d = 1'b0;
              state_d = EXEC;
            end
            MUL_OP: begin
              mul_start_c = 1'b1;
              ready_d     = 1'b0;
              state_d     = MUL;
            end
            RST_OP:  result_d = '0;
            default: ;
          endcase
        end
      end
      EXEC: begin
        case (op_q)
          ADD_OP:  result_d = RW'((W + 1)'(a_q) + (W + 1)'(b_q));
          AND_OP:  result_d = RW'(a_q & b_q);
          XOR_OP:  result_d = RW'(a_q ^ b_q);
          default: result_d = result_q;
        endcase
        done_d  = 1'b1;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      MUL: begin
        if (mul_last_c) begin
          result_d = mul_product_c;
          done_d   = 1'b1;
          ready_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_all_c) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      op_q     <= NO_OP;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      result_q <= result_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core (W=8): directed scenarios then random traffic,
// compared each cycle against a transaction-level reference model.
module tb_alu_core;

  logic        clk;
  logic        rst;
  logic        alu_rst;
  logic        ready;
  logic        valid;
  logic [2:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        done;
  logic [15:0] result;

  int n_checks;
  int n_fail;

  // Reference model: remaining latency plus the result waiting to be published.
  bit          m_ready;
  bit          m_done;
  logic [15:0] m_res;
  logic [15:0] m_pend;
  int          m_left;

  alu_core #(.ALU_IN_OP_WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .alu_rst (alu_rst),
    .ready   (ready),
    .valid   (valid),
    .op      (op),
    .a       (a),
    .b       (b),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst || alu_rst) begin
      m_ready = 1'b0;
      m_done  = 1'b0;
      m_res   = '0;
      m_left  = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_res   = m_pend;
          m_done  = 1'b1;
          m_ready = 1'b1;
        end
      end else if (valid && m_ready) begin
        case (op)
          3'd1: begin m_pend = 16'(int'(a) + int'(b)); m_left = 1; m_ready = 1'b0; end
          3'd2: begin m_pend = {8'h00, a & b};          m_left = 1; m_ready = 1'b0; end
          3'd3: begin m_pend = {8'h00, a ^ b};          m_left = 1; m_ready = 1'b0; end
          3'd4: begin m_pend = 16'(int'(a) * int'(b)); m_left = 8; m_ready = 1'b0; end
          3'd7: m_res = '0;
          default: ;
        endcase
      end else begin
        m_ready = 1'b1;
      end
    end
  endtask

  // One clock: model advances on the edge, DUT is compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("ready",  32'(ready),  32'(m_ready));
    check_eq("done",   32'(done),   32'(m_done));
    check_eq("result", 32'(result), 32'(m_res));
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    valid = v;
    op    = o;
    a     = x;
    b     = y;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_ready  = 1'b0;
    m_done   = 1'b0;
    m_res    = '0;
    m_pend   = '0;
    m_left   = 0;
    rst      = 1'b1;
    alu_rst  = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00);

    // Reset for two cycles, then ready rises one edge after release
    cycle();
    cycle();
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_result", 32'(result), 32'h0000);
    rst = 1'b0;
    cycle();
    check_eq("ready_after_rst", 32'(ready), 32'd1);

    // ADD with carry into bit W
    drive(1'b1, 3'd1, 8'hFF, 8'h01);
    cycle();
    check_eq("add_busy", 32'(ready), 32'd0);
    drive(1'b0, 3'd0, 8'hAA, 8'h55);
    cycle();
    check_eq("add_done", 32'(done), 32'd1);
    check_eq("add_result", 32'(result), 32'h0100);
    cycle();
    check_eq("add_done_drop", 32'(done), 32'd0);

    // MUL with ignored valid pulses and operand churn while busy
    drive(1'b1, 3'd4, 8'hFF, 8'hFF);
    cycle();
    for (int i = 0; i < 7; i++) begin
      drive(1'(i % 2), 3'd1, 8'(i * 17), 8'(i * 3));
      cycle();
      check_eq("mul_busy_done", 32'(done), 32'd0);
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    cycle();
    check_eq("mul_done", 32'(done), 32'd1);
    check_eq("mul_result", 32'(result), 32'hFE01);

    // AND followed by XOR at the first ready edge
    drive(1'b1, 3'd2, 8'hF0, 8'h3C);
    cycle();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    cycle();
    check_eq("and_result", 32'(result), 32'h0030);
    drive(1'b1, 3'd3, 8'hF0, 8'h3C);
    cycle();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    cycle();
    check_eq("xor_done", 32'(done), 32'd1);
    check_eq("xor_result", 32'(result), 32'h00CC);

    // Soft reset aborts a multiply
    drive(1'b1, 3'd4, 8'h12, 8'h34);
    cycle();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    cycle();
    cycle();
    alu_rst = 1'b1;
    cycle();
    check_eq("abort_result", 32'(result), 32'h0000);
    check_eq("abort_ready", 32'(ready), 32'd0);
    alu_rst = 1'b0;
    cycle();
    check_eq("abort_ready_back", 32'(ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cycle();
      check_eq("abort_no_done", 32'(done), 32'd0);
    end
    drive(1'b1, 3'd1, 8'h02, 8'h03);
    cycle();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    cycle();
    check_eq("add_after_abort", 32'(result), 32'h0005);

    // NO_OP, unused opcode 5, then RST_OP
    drive(1'b1, 3'd1, 8'hFF, 8'h01);
    cycle();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    cycle();
    drive(1'b1, 3'd0, 8'h11, 8'h22);
    cycle();
    check_eq("noop_done", 32'(done), 32'd0);
    check_eq("noop_result", 32'(result), 32'h0100);
    drive(1'b1, 3'd5, 8'h11, 8'h22);
    cycle();
    check_eq("op5_ready", 32'(ready), 32'd1);
    check_eq("op5_result", 32'(result), 32'h0100);
    drive(1'b1, 3'd7, 8'h11, 8'h22);
    cycle();
    check_eq("rstop_result", 32'(result), 32'h0000);
    check_eq("rstop_ready", 32'(ready), 32'd1);
    check_eq("rstop_done", 32'(done), 32'd0);

    // Random traffic with occasional resets of either kind
    for (int i = 0; i < 1500; i++) begin
      rst     = ($urandom_range(0, 149) == 0);
      alu_rst = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
